// File: rtl/ctrl_uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// ctrl_uart_tx_fifo_if
// Bus bundle between the TX register decode (master) and the buffered UART
// transmitter (slave).
//   wr_en/wr_dat : byte push request and data
//   wr_ack       : push accepted (FIFO not full)
//   flush        : single-cycle FIFO empty request
//   ovf_clr      : clears the sticky overflow flag
//   full/empty/level/ovf/tx_busy : status for the UART status register
//   uart_txd     : serial line out
// -----------------------------------------------------------------------------
interface ctrl_uart_tx_fifo_if #(
   parameter int AW = 4
);
   logic          wr_en;
   logic [7:0]    wr_dat;
   logic          wr_ack;
   logic          flush;
   logic          ovf_clr;
   logic          full;
   logic          empty;
   logic [AW:0]   level;
   logic          ovf;
   logic          tx_busy;
   logic          uart_txd;

   modport master (
      output wr_en, wr_dat, flush, ovf_clr,
      input  wr_ack, full, empty, level, ovf, tx_busy, uart_txd
   );

   modport slave (
      input  wr_en, wr_dat, flush, ovf_clr,
      output wr_ack, full, empty, level, ovf, tx_busy, uart_txd
   );
endinterface

// File: rtl/ctrl_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// ctrl_uart_tx_fifo
// Buffered 8N1 UART transmitter. Register writes push bytes into a 2^AW deep
// circular FIFO; a serializer drains it onto uart_txd at BAUD_CNT clocks/bit.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous, active-low reset
//   bus    : ctrl_uart_tx_fifo_if.slave (push, flush, ovf_clr in; status and
//            uart_txd out)
// -----------------------------------------------------------------------------
module ctrl_uart_tx_fifo #(
   parameter int AW       = 4,
   parameter int BAUD_CNT = 434,
   parameter int BCW      = 9
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ctrl_uart_tx_fifo_if.slave   bus
);

   localparam int             DEPTH    = 1 << AW;
   localparam logic [BCW-1:0] BAUD_TOP = BCW'(BAUD_CNT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t          r_state;
   logic [BCW-1:0]  r_baud;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic            r_txd;
   logic            r_ovf;
   logic [AW:0]     r_wr_ptr;
   logic [AW:0]     r_rd_ptr;
   logic [7:0]      r_mem [DEPTH];

   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_baud_done;
   logic [7:0]      w_rd_dat;

   // Extra pointer MSB distinguishes full from empty when low bits match.
   assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_baud_done = (r_baud == '0);
   assign w_rd_dat    = r_mem[r_rd_ptr[AW-1:0]];

   // Flush overrides both push and pop in the same cycle so the discarded
   // bytes can never reach the line.
   assign w_push = bus.wr_en && !w_full && !bus.flush;
   assign w_pop  = !w_empty && !bus.flush &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));

   // FIFO pointers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (bus.flush) begin
         r_rd_ptr <= r_wr_ptr;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // FIFO storage (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.wr_dat;
   end

   // Sticky overflow: a dropped push takes priority over a clear request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (bus.wr_en && w_full && !bus.flush) begin
         r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   // Serializer: uart_txd is set together with each state change so the
   // registered line level always matches the state being entered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_txd   <= 1'b1;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_txd <= 1'b1;
               if (w_pop) begin
                  r_shift <= w_rd_dat;
                  r_baud  <= BAUD_TOP;
                  r_txd   <= 1'b0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_baud_done) begin
                  r_baud  <= BAUD_TOP;
                  r_bit   <= '0;
                  r_txd   <= r_shift[0];
                  r_state <= S_DATA;
               end else begin
                  r_baud <= r_baud - 1'b1;
               end
            end
            S_DATA: begin
               if (w_baud_done) begin
                  r_baud <= BAUD_TOP;
                  if (r_bit == 3'd7) begin
                     r_txd   <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_txd   <= r_shift[1];
                     r_bit   <= r_bit + 1'b1;
                  end
               end else begin
                  r_baud <= r_baud - 1'b1;
               end
            end
            S_STOP: begin
               if (w_baud_done) begin
                  // Back-to-back frames: go straight to START with no idle gap.
                  if (w_pop) begin
                     r_shift <= w_rd_dat;
                     r_baud  <= BAUD_TOP;
                     r_txd   <= 1'b0;
                     r_state <= S_START;
                  end else begin
                     r_txd   <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_baud <= r_baud - 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_txd   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.wr_ack   = !w_full;
   assign bus.full     = w_full;
   assign bus.empty    = w_empty;
   assign bus.level    = r_wr_ptr - r_rd_ptr;
   assign bus.ovf      = r_ovf;
   assign bus.tx_busy  = (r_state != S_IDLE);
   assign bus.uart_txd = r_txd;

endmodule

// File: tb/tb_ctrl_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_ctrl_uart_tx_fifo
// Directed bench for ctrl_uart_tx_fifo with AW=2 (depth 4), BAUD_CNT=4.
// -----------------------------------------------------------------------------
module tb_ctrl_uart_tx_fifo;

   localparam int AW   = 2;
   localparam int BAUD = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   ctrl_uart_tx_fifo_if #(.AW(AW)) bus ();

   ctrl_uart_tx_fifo #(
      .AW       (AW),
      .BAUD_CNT (BAUD),
      .BCW      (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Checks uart_txd on every clock of a frame, from clock index first to
   // last (index 0 = first clock of the start bit), ticking after each.
   task automatic check_frame(input string tag, input logic [7:0] b,
                              input int first, input int last);
      int   bi;
      logic e;
      for (int i = first; i <= last; i++) begin
         bi = i / BAUD;
         if (bi == 0)      e = 1'b0;
         else if (bi == 9) e = 1'b1;
         else              e = b[bi-1];
         check(tag, bus.uart_txd, e);
         tick();
      end
   endtask

   function automatic logic [7:0] wrap_byte(input int i);
      return 8'(i * 37 + 11);
   endfunction

   initial begin
      int   sent;
      int   budget;
      int   t;
      logic [7:0] rx;
      logic rx_dead;

      n_checks      = 0;
      n_errors      = 0;
      rst_n         = 1'b0;
      bus.wr_en     = 1'b0;
      bus.wr_dat    = 8'h00;
      bus.flush     = 1'b0;
      bus.ovf_clr   = 1'b0;

      // Reset
      tick();
      tick();
      check("rst_txd",   bus.uart_txd, 1);
      check("rst_empty", bus.empty,    1);
      check("rst_level", bus.level,    0);
      check("rst_ovf",   bus.ovf,      0);
      check("rst_busy",  bus.tx_busy,  0);
      check("rst_ack",   bus.wr_ack,   1);
      check("rst_full",  bus.full,     0);
      rst_n = 1'b1;

      // Single byte 0x55
      bus.wr_en = 1'b1; bus.wr_dat = 8'h55;
      tick();
      bus.wr_en = 1'b0;
      check("b55_pre_txd",   bus.uart_txd, 1);
      check("b55_pre_level", bus.level,    1);
      check("b55_pre_busy",  bus.tx_busy,  0);
      tick();
      check("b55_busy", bus.tx_busy, 1);
      check_frame("b55_frame", 8'h55, 0, 39);
      check("b55_done_busy", bus.tx_busy,  0);
      check("b55_done_txd",  bus.uart_txd, 1);

      // Three bytes back-to-back
      bus.wr_en = 1'b1; bus.wr_dat = 8'h01;
      tick();
      bus.wr_dat = 8'h80;
      tick();
      check("b3_start", bus.uart_txd, 0);
      bus.wr_dat = 8'hA5;
      tick();
      bus.wr_en = 1'b0;
      check("b3_level2", bus.level, 2);
      check_frame("b3_f01", 8'h01, 1, 39);
      check("b3_level1", bus.level, 1);
      check_frame("b3_f80", 8'h80, 0, 39);
      check("b3_level0", bus.level, 0);
      check_frame("b3_fa5", 8'hA5, 0, 39);
      check("b3_idle", bus.tx_busy, 0);

      // Fill with the serializer busy on 0x11
      bus.wr_en = 1'b1; bus.wr_dat = 8'h11;
      tick();
      bus.wr_en = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         bus.wr_en = 1'b1; bus.wr_dat = 8'(8'h21 + k);
         tick();
         check("fill_level", bus.level, k + 1);
      end
      check("fill_full", bus.full,   1);
      check("fill_ack",  bus.wr_ack, 0);
      check("fill_ovf0", bus.ovf,    0);
      bus.wr_dat = 8'h25;
      tick();
      bus.wr_en = 1'b0;
      check("ovf_set",   bus.ovf,   1);
      check("ovf_level", bus.level, 4);
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      check("ovf_clr", bus.ovf, 0);
      bus.wr_en = 1'b1; bus.wr_dat = 8'h27; bus.ovf_clr = 1'b1;
      tick();
      bus.wr_en = 1'b0;
      check("ovf_set_wins", bus.ovf, 1);
      tick();
      bus.ovf_clr = 1'b0;
      check("ovf_clr2",   bus.ovf,   0);
      check("ovf_level2", bus.level, 4);
      check_frame("fill_f11", 8'h11, 8, 39);
      check("fill_lvl3", bus.level, 3);
      check_frame("fill_f21", 8'h21, 0, 39);
      check_frame("fill_f22", 8'h22, 0, 38);
      // Push lands on the same edge as the 0x23 pop
      check("pp_stop", bus.uart_txd, 1);
      check("pp_level_pre", bus.level, 2);
      bus.wr_en = 1'b1; bus.wr_dat = 8'h26;
      tick();
      bus.wr_en = 1'b0;
      check("pp_level_post", bus.level, 2);
      check_frame("fill_f23", 8'h23, 0, 39);
      check_frame("fill_f24", 8'h24, 0, 39);
      check_frame("fill_f26", 8'h26, 0, 39);
      check("fill_idle",  bus.tx_busy, 0);
      check("fill_empty", bus.empty,   1);

      // Flush mid-frame, with a simultaneous push that must be discarded
      for (int k = 0; k < 4; k++) begin
         bus.wr_en = 1'b1; bus.wr_dat = 8'(8'h31 + k);
         tick();
      end
      bus.wr_en = 1'b0;
      check("fl_level3", bus.level, 3);
      bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_dat = 8'h35;
      tick();
      bus.flush = 1'b0; bus.wr_en = 1'b0;
      check("fl_empty", bus.empty, 1);
      check("fl_level", bus.level, 0);
      check("fl_ovf",   bus.ovf,   0);
      check_frame("fl_f31", 8'h31, 3, 39);
      for (int k = 0; k < 8; k++) begin
         check("fl_quiet_txd",  bus.uart_txd, 1);
         check("fl_quiet_busy", bus.tx_busy,  0);
         tick();
      end

      // Reset in the middle of the DATA phase
      bus.wr_en = 1'b1; bus.wr_dat = 8'hF0;
      tick();
      bus.wr_en = 1'b0;
      tick();
      for (int k = 0; k < 6; k++) tick();
      check("rd_in_data", bus.uart_txd, 0);
      rst_n = 1'b0;
      tick();
      check("rd_txd",   bus.uart_txd, 1);
      check("rd_busy",  bus.tx_busy,  0);
      check("rd_empty", bus.empty,    1);
      rst_n = 1'b1;
      tick();
      check("rd_txd2",  bus.uart_txd, 1);
      check("rd_busy2", bus.tx_busy,  0);

      // Wrap: 20 bytes streamed through the depth-4 FIFO
      sent    = 0;
      rx_dead = 1'b0;
      fork
         begin
            budget = 0;
            while (sent < 20 && budget < 3000) begin
               if (bus.wr_ack) begin
                  bus.wr_en  = 1'b1;
                  bus.wr_dat = wrap_byte(sent);
                  sent++;
               end else begin
                  bus.wr_en = 1'b0;
               end
               tick();
               budget++;
            end
            bus.wr_en = 1'b0;
            check("wrap_sent", sent, 20);
         end
         begin
            for (int k = 0; k < 20 && !rx_dead; k++) begin
               t = 0;
               while (bus.uart_txd !== 1'b0 && t < 200) begin
                  tick();
                  t++;
               end
               if (t >= 200) begin
                  check("wrap_rx_start_timeout", bus.uart_txd, 0);
                  rx_dead = 1'b1;
               end else begin
                  tick(); tick();
                  check("wrap_rx_start", bus.uart_txd, 0);
                  for (int j = 0; j < 8; j++) begin
                     for (int c = 0; c < BAUD; c++) tick();
                     rx[j] = bus.uart_txd;
                  end
                  for (int c = 0; c < BAUD; c++) tick();
                  check("wrap_rx_stop", bus.uart_txd, 1);
                  check("wrap_rx_byte", rx, wrap_byte(k));
               end
            end
         end
      join
      for (int c = 0; c < 2 * BAUD; c++) tick();
      check("wrap_ovf",   bus.ovf,     0);
      check("wrap_empty", bus.empty,   1);
      check("wrap_idle",  bus.tx_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ctrl_uart_tx_fifo.md
Name: ctrl_uart_tx_fifo

Overview:
Buffered UART transmitter that sits directly downstream of the control-register decode. It replaces the single-character TX path, so the CPU can queue up to 2^AW bytes without stalling on every character. Register writes push bytes into a circular FIFO. An 8N1 serializer drains the FIFO onto uart_txd at a fixed baud rate and reports status back for the UART status register.

Parameters:
AW, 4, FIFO address width; depth = 2^AW entries.
BAUD_CNT, 434, clocks per bit (115200 baud at 50 MHz); must be >= 2.
BCW, 9, width of the baud counter; must hold BAUD_CNT-1.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active low
wr_en  in  1  push request (from TX register write decode: cs && we && address match)
wr_dat  in  8  byte to push
wr_ack  out  1  combinational; = !full, used as bus ack for the TX register
flush  in  1  single-cycle pulse; empties the FIFO
ovf_clr  in  1  clears the sticky overflow flag
full  out  1  FIFO holds 2^AW entries
empty  out  1  FIFO holds 0 entries
level  out  AW+1  current entry count, 0..2^AW
ovf  out  1  sticky; set on a push attempted while full
tx_busy  out  1  serializer not in IDLE
uart_txd  out  1  serial output, registered, idle high

Behaviour:
- One clock domain; all state updates on posedge clk. Reset is synchronous and active-low; no asynchronous reset anywhere.
- Reset (rst_n=0 at an edge): state=IDLE, uart_txd=1, wr/rd pointers=0, level=0, empty=1, full=0, ovf=0, tx_busy=0, baud and bit counters=0.
- A reset asserted mid-frame aborts the frame; uart_txd returns to 1 at the next edge.
- FIFO storage and pointers:
  - Storage is 2^AW x 8.
  - Read/write pointers are AW+1 bits wide.
  - full = MSBs differ and the low AW bits are equal; empty = pointers equal.
  - Pointers wrap naturally modulo 2^(AW+1).
- Push: on wr_en && !full, store wr_dat at the write pointer and increment it.
- Push while full: data is dropped, the pointer is unchanged, and ovf is set to 1.
- Pop: the serializer pops only in IDLE or at the end of STOP, and only when !empty.
- Level: a push and a pop in the same cycle leave level unchanged. A push into an empty FIFO during the same cycle the serializer checks empty is not popped until the next cycle (empty is evaluated from registered pointers).
- Flush: both pointers are set equal (rd_ptr <= wr_ptr) and level becomes 0. A frame already in flight completes normally.
  - flush and wr_en in the same cycle: flush wins and the byte is discarded; ovf is unaffected.
- ovf: ovf_clr clears it. If a set event and ovf_clr occur in the same cycle, the set wins.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_txd=1. If !empty: pop into an 8-bit shift register, load the baud counter with BAUD_CNT-1, go to START.
  - START: uart_txd=0 for BAUD_CNT clocks. When the baud counter reaches 0: go to DATA with bit count 0.
  - DATA: uart_txd=shift[0], LSB first. Each time the baud counter reaches 0: shift right and increment the bit count. After bit 7 has lasted its full BAUD_CNT clocks, go to STOP.
  - STOP: uart_txd=1 for BAUD_CNT clocks. At the end: if !empty, pop and go straight to START (no idle gap); else go to IDLE.
- uart_txd is registered. Every bit lasts exactly BAUD_CNT clocks; a frame lasts exactly 10*BAUD_CNT clocks.
- Latency: a push at edge N into an empty FIFO with the serializer idle gives the pop at edge N+1, and uart_txd falls after edge N+1.
- tx_busy = (state != IDLE).

Test Plan:
- Reset, BAUD_CNT=4: hold rst_n=0 for 2 clocks -> uart_txd=1, empty=1, level=0, ovf=0, tx_busy=0, wr_ack=1.
- Single byte 0x55 pushed at edge N with FIFO idle -> txd low from edge N+1 for 4 clocks, then bits 1,0,1,0,1,0,1,0 (4 clocks each), then high for 4 clocks; tx_busy falls after 40 clocks.
- Push 3 bytes (0x01, 0x80, 0xA5) back-to-back -> three contiguous 40-clock frames with no idle gap. level reads 2 after the first pop, then decrements at each frame boundary.
- Fill, AW=2: push 5 bytes while the serializer is stalled mid-frame -> after the 4th push full=1 and wr_ack=0; the 5th push is dropped and ovf=1. ovf_clr pulse -> ovf=0.
- Same-cycle push and pop at level=2 -> level stays 2. Wrap test: 20 bytes streamed through a depth-4 FIFO -> all 20 transmitted in order with no corruption.
- Flush with 3 queued bytes mid-frame -> current frame completes, empty=1 afterward, and no further frames are sent. Reset pulse mid-DATA -> uart_txd=1 on the next edge, state IDLE.
